// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types, constants and helpers for the 4-way round-robin mux arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mux4_rr_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // One-hot vector with only bit idx set.
  function automatic logic [NUM_REQ-1:0] onehot4(input logic [SEL_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Request/data bundle between four requesters and the shared mux arbiter.
// Latency: n/a (wires only).
// Backpressure: none; requesters simply hold req until they see their gnt bit.
interface mux4_rr_arbiter_if;
  import mux4_rr_arbiter_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] in;
  logic [NUM_REQ-1:0] gnt;
  logic [SEL_W-1:0]   sel;
  logic               valid;
  logic               out;

  // Requester side: drives requests and data, observes grant and mux output.
  modport master (
    output req,
    output in,
    input  gnt,
    input  sel,
    input  valid,
    input  out
  );

  // Arbiter side.
  modport slave (
    input  req,
    input  in,
    output gnt,
    output sel,
    output valid,
    output out
  );

endinterface

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Circular first-set search over four candidates starting just after last.
// Latency: combinational.
// Backpressure: none; any=0 when no candidate is set.
module rr_pick4
  import mux4_rr_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] cand_i,
  input  logic [SEL_W-1:0]   last_i,
  output logic [SEL_W-1:0]   idx_o,
  output logic               any_o
);

  // Walk offsets from farthest (last itself) to nearest so the nearest set bit wins.
  always_comb begin
    logic [SEL_W-1:0] pos;
    idx_o = '0;
    any_o = 1'b0;
    pos   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      pos = last_i + SEL_W'(k);
      if (cand_i[pos]) begin
        idx_o = pos;
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning a 4:1 single-bit mux, with a bounded hold time per owner.
// Latency: request to grant 1 cycle; data path in->out combinational once granted.
// Backpressure: none; an owner is preempted after MAX_HOLD cycles while others wait.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mux4_rr_arbiter_if.slave       bus
);

  localparam int unsigned HW = $clog2(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q,   gnt_d;
  logic [SEL_W-1:0]   sel_q,   sel_d;
  logic               valid_q, valid_d;
  logic [SEL_W-1:0]   last_q,  last_d;
  logic [HW-1:0]      hold_q,  hold_d;

  logic [NUM_REQ-1:0] cand;
  logic [SEL_W-1:0]   pick_idx;
  logic               pick_any;

  // While busy the owner is excluded so it is never re-picked over a waiter.
  assign cand = (state_q == BUSY) ? (bus.req & ~onehot4(last_q)) : bus.req;

  rr_pick4 u_pick (
    .cand_i (cand),
    .last_i (last_q),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  // Next-state: initial grant, release/handoff, forced rotation, or keep holding.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    last_d  = last_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d   = onehot4(pick_idx);
          sel_d   = pick_idx;
          valid_d = 1'b1;
          last_d  = pick_idx;
          hold_d  = '0;
          state_d = BUSY;
        end else begin
          gnt_d   = '0;
          valid_d = 1'b0;
        end
      end
      BUSY: begin
        if (!bus.req[last_q]) begin
          // Owner let go: hand straight to a waiter, or fall back to idle.
          if (pick_any) begin
            gnt_d  = onehot4(pick_idx);
            sel_d  = pick_idx;
            last_d = pick_idx;
            hold_d = '0;
          end else begin
            gnt_d   = '0;
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end else if ((hold_q == HOLD_LAST) && pick_any) begin
          gnt_d  = onehot4(pick_idx);
          sel_d  = pick_idx;
          last_d = pick_idx;
          hold_d = '0;
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State register; reset makes requester 0 the first in line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= SEL_W'(NUM_REQ - 1);
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.sel   = sel_q;
  assign bus.valid = valid_q;
  assign bus.out   = valid_q ? bus.in[sel_q] : 1'b0;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;

  localparam int MH = 4;

  logic clk;
  logic rst_n;

  mux4_rr_arbiter_if bus ();

  mux4_rr_arbiter #(.MAX_HOLD(MH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic       out;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Reference model: owner index (-1 = nobody), last winner, cycles held so far.
  int m_owner = -1;
  int m_last  = 3;
  int m_held  = 0;
  int m_sel   = 0;

  function automatic int rr_pick(input int r, input int last);
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (last + k) % 4;
      if (((r >> i) & 1) == 1) return i;
    end
    return -1;
  endfunction

  function automatic void model_grant(input int w);
    m_owner = w;
    m_last  = w;
    m_sel   = w;
    m_held  = 1;
  endfunction

  function automatic void model_edge(input bit rst, input int r);
    int others;
    int w;
    if (!rst) begin
      m_owner = -1; m_last = 3; m_held = 0; m_sel = 0;
    end else if (m_owner < 0) begin
      w = rr_pick(r, m_last);
      if (w >= 0) model_grant(w);
    end else begin
      others = r & ~(1 << m_owner);
      if (((r >> m_owner) & 1) == 0) begin
        w = rr_pick(others, m_owner);
        if (w >= 0) model_grant(w);
        else m_owner = -1;
      end else if (m_held >= MH && others != 0) begin
        model_grant(rr_pick(others, m_owner));
      end else if (m_held < MH) begin
        m_held++;
      end
    end
  endfunction

  // Drive one cycle of inputs, predict the post-edge outputs, wait past the edge.
  task automatic step(input bit rst, input logic [3:0] r, input logic [3:0] d, input string tag);
    exp_t e;
    rst_n   = rst;
    bus.req = r;
    bus.in  = d;
    model_edge(rst, int'(r));
    e.gnt   = (m_owner < 0) ? 4'b0 : 4'(1 << m_owner);
    e.sel   = 2'(m_sel);
    e.valid = (m_owner >= 0);
    e.out   = (m_owner >= 0) ? d[m_owner] : 1'b0;
    e.tag   = tag;
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req_v, $time);
    end
  endtask

  // Monitor: after each edge, pop the prediction for that edge and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cmp({e.tag, ".gnt"},   bus.gnt,            e.gnt);
        cmp({e.tag, ".sel"},   {2'b0, bus.sel},    {2'b0, e.sel});
        cmp({e.tag, ".valid"}, {3'b0, bus.valid},  {3'b0, e.valid});
        cmp({e.tag, ".out"},   {3'b0, bus.out},    {3'b0, e.out});
        cmp({e.tag, ".inv_valid"}, {3'b0, bus.valid}, {3'b0, |bus.gnt});
        if (bus.valid)
          cmp({e.tag, ".inv_onehot"}, bus.gnt, 4'(1 << bus.sel));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] r;
    logic [3:0] d;
    int wait_cyc;
    rst_n   = 1'b0;
    bus.req = '0;
    bus.in  = '0;
    #2;

    // 1. Reset holds outputs low even with all requests up; then 0 wins first.
    step(0, 4'hF, 4'hF, "reset0");
    step(0, 4'hF, 4'hF, "reset1");
    step(1, 4'hF, 4'hF, "rst_release");

    // 2. Single requester, data follows in, then release to idle.
    step(0, 4'h0, 4'h0, "single_rst");
    step(1, 4'b0100, 4'b0100, "single_gnt");
    step(1, 4'b0100, 4'b0000, "single_toggle0");
    step(1, 4'b0100, 4'b0100, "single_toggle1");
    step(1, 4'b0000, 4'b0100, "single_drop");
    step(1, 4'b0000, 4'b0100, "single_idle");

    // 3. Fairness: all requesting, each owner held MAX_HOLD cycles.
    step(0, 4'h0, 4'h0, "fair_rst");
    for (int i = 0; i < 5 * MH; i++) step(1, 4'hF, 4'($urandom_range(0, 15)), "fair");

    // 4. Owner releases while others wait: handoff without an idle cycle.
    step(0, 4'h0, 4'h0, "handoff_rst");
    step(1, 4'b0001, 4'b0001, "handoff_own");
    step(1, 4'b0001, 4'b0000, "handoff_own2");
    step(1, 4'b1010, 4'b0010, "handoff");
    step(1, 4'b1010, 4'b1000, "handoff_next");

    // 5. Sole owner keeps the mux indefinitely, then yields within MAX_HOLD.
    step(0, 4'h0, 4'h0, "sole_rst");
    for (int i = 0; i < 20; i++) step(1, 4'b1000, 4'($urandom_range(0, 15)), "sole");
    for (int i = 0; i < MH + 1; i++) step(1, 4'b1001, 4'($urandom_range(0, 15)), "sole_wrap");
    step(0, 4'h0, 4'h0, "wrap_rst");
    step(1, 4'b1001, 4'b0001, "wrap_idle");

    // 6. Reset mid-operation drops the grant and restores priority to 0.
    step(0, 4'h0, 4'h0, "mid_rst0");
    step(1, 4'b0100, 4'b0100, "mid_own");
    step(0, 4'b0110, 4'b0110, "mid_rst");
    step(1, 4'b0110, 4'b0110, "mid_after");

    // Randomized traffic with sticky requests so holds can expire.
    r = 4'($urandom_range(0, 15));
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      d = 4'($urandom_range(0, 15));
      step(($urandom_range(0, 99) != 0), r, d, "rand");
    end

    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    #3;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d predictions left, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
Round-robin arbiter that shares one 4:1 single-bit data mux among four requesters. It samples the request lines and registers a one-hot grant and the matching 2-bit mux select. It drives the selected data bit to a shared output. It limits how long one owner holds the mux while others are waiting, so no requester is starved.

Parameters:
MAX_HOLD, 8, maximum consecutive grant cycles for one owner while any other requester is pending; legal range 2..256.

Ports:
clk    input   1  system clock; all state updates on the rising edge
rst_n  input   1  synchronous reset, active-low, sampled on the clk rising edge
req    input   4  request lines; req[i] high = requester i wants the mux
in     input   4  data bits; in[i] belongs to requester i
gnt    output  4  registered one-hot grant; all zeros when idle
sel    output  2  registered mux select; equals the index of the set gnt bit
valid  output  1  registered; high while some requester holds a grant
out    output  1  combinational; in[sel] when valid=1, else 0

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - gnt=0, sel=0, valid=0, so out=0.
  - Internal state: state=IDLE, last=3 (requester 0 has top priority first), hold_cnt=0.
  - Reset has priority over every other event. A grant active mid-operation is dropped on the next edge.
- Circular search: pick the first set bit of the candidate vector, scanning last+1, last+2, ... with wrap 3→0. The owner is therefore lowest priority in any search.
- State IDLE:
  - If req≠0 at an edge: winner = search(req). gnt=onehot(winner), sel=winner, valid=1, last=winner, hold_cnt=0, go to BUSY.
  - Request-to-grant latency is 1 cycle.
  - If req=0: stay in IDLE with outputs at reset values.
- State BUSY (owner = last). Evaluate at each edge in this order:
  1. Release: req[owner]=0. others = req with the owner bit cleared.
     - others≠0: grant search(others) on the same edge, hold_cnt=0. No idle bubble.
     - others=0: gnt=0, valid=0, sel holds its value, go to IDLE.
  2. Forced rotation: req[owner]=1, hold_cnt=MAX_HOLD-1, others≠0. Grant search(others), hold_cnt=0.
  3. Otherwise the owner keeps the grant.
     - hold_cnt increments, saturating at MAX_HOLD-1.
     - If others=0, the owner keeps the grant indefinitely with hold_cnt saturated.
- Only the current req value is considered. A request that drops before it is granted is lost; there is no request latching.
- Release and hold expiry on the same edge are handled as a release.
- A grant is only ever given to a requester with req high on that edge.
- Width rules:
  - hold_cnt is $clog2(MAX_HOLD) bits and is compared against MAX_HOLD-1.
  - last and sel are 2 bits; wrap is modulo 4.
- Invariants for assertions:
  - gnt is always one-hot or zero.
  - valid == |gnt.
  - When valid=1, gnt == 1<<sel.
  - Each owner holds the grant for at most MAX_HOLD consecutive cycles while others≠0.

Decomposition:
- Shared package:
  - State enum {IDLE, BUSY}.
  - NUM_REQ=4 and SEL_W=2 constants.
  - Function onehot4(idx).
- One sub-module, rr_pick4 (combinational):
  - Inputs: cand[3:0], last[1:0].
  - Outputs: idx[1:0], any.
  - Used for both the IDLE search and the BUSY search.
- The output data selection is a plain 4:1 mux on sel, gated by valid.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles with req=4'hF, in=4'hF → gnt=0, sel=0, valid=0, out=0 throughout. On the first edge after release, gnt=4'b0001.
2. Single request: from IDLE, req=4'b0100, in=4'b0100 → one edge later gnt=4'b0100, sel=2, valid=1, out=1. Then toggle in[2]; out follows in the same cycle. Drop req → next edge gnt=0, valid=0, out=0.
3. Fairness, MAX_HOLD=4: req=4'hF held constant → gnt sequence 0001×4, 0010×4, 0100×4, 1000×4, 0001×4.
4. No-bubble handoff: owner 0 holds; req changes 4'b0001→4'b1010 → next edge gnt=4'b0010 and valid stays 1 with no zero cycle.
5. Wrap and sole owner: owner 3 holds with req=4'b1000 for 20 cycles → gnt stays 1000 and hold_cnt saturates. Then req=4'b1001 → gnt=0001 within MAX_HOLD cycles. Also check from IDLE with last=3 and req=4'b1001 → gnt=0001.
6. Reset mid-operation: gnt=0100 and req=4'b0110, pulse rst_n=0 for 1 cycle → gnt=0 on that edge. On the next edge gnt=0010, because last was reset to 3.
